des_expand_mix_pipe: RTL and testbench
======================================

Name: des_expand_mix_pipe

Overview:
- Parametrised successor to the DES E-box expansion used in the round function.
- Expands the 32-bit right half to 48 bits with the standard DES E table and XORs the result with the 48-bit round subkey.
- Carries both through a NUM_STAGES-deep elastic valid/ready pipeline, with a sideband tag.
- Sits between the round L/R registers and the S-box bank in the pipelined DES datapath.

Parameters:
- NUM_STAGES, 2, number of registered pipeline stages (legal 1..4); latency in cycles when unstalled.
- TAG_W, 4, width of the sideband tag (round index / channel id) carried alongside the data.
- XOR_KEY, 1, 1 = output is E(R) XOR subkey; 0 = output is E(R) only, subkey ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage 1 can accept a beat.
- right_half  input  32  R input, bit 31 = DES bit 1.
- subkey  input  48  round key, bit 47 = DES key bit 1.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- sbox_in  output  48  mixed result; group g (g = 0..7) = bits [47-6g -: 6] feeds S-box g+1.
- out_tag  output  TAG_W  tag of the current output beat.
- occupancy  output  $clog2(NUM_STAGES+1)  number of valid beats held in the pipe.

Behaviour:
- Expansion, combinational in front of stage 1. For group g, the six bits MSB-first are:
  - R[(32-4g) mod 32], R[31-4g], R[30-4g], R[29-4g], R[28-4g], R[(27-4g+32) mod 32].
  - Hence sbox_in[47] = R[0] and sbox_in[0] = R[31] (wrap-around at both ends).
- Mix: stage 1 captures E(R) ^ subkey when XOR_KEY = 1, or E(R) when XOR_KEY = 0. Stages 2..NUM_STAGES are pure delay.
- Stage structure: each stage has a valid bit plus data and tag registers.
  - ready_k = !valid_k || ready_(k+1).
  - The last stage uses out_ready as ready_(k+1).
  - in_ready = ready_1.
- Transfers: a beat moves into stage k when the upstream stage is valid and ready_k = 1. Stage data registers load only on a transfer.
- Bubbles: a bubble collapses in the same cycle, so full throughput is one beat per cycle with out_ready held high.
- Latency: exactly NUM_STAGES cycles from an accepted input to out_valid when no stall occurs.
- Back-pressure: while out_valid && !out_ready, sbox_in, out_tag and out_valid hold stable. Upstream stages keep filling until full, then in_ready = 0.
- Occupancy:
  - occupancy = number of set stage valid bits, updated every cycle.
  - Range 0..NUM_STAGES; in_ready = 0 only when occupancy == NUM_STAGES and out_ready = 0.
- Simultaneous events: an accept and an emit in the same cycle leave occupancy unchanged. There is no loss or duplication.
- Input rule: in_valid is not required to wait for in_ready. Inputs presented while in_ready = 0 are not taken and must be held by the source (AXI-style).
- Reset (async assert, sync deassert by the reset tree):
  - All valid bits cleared; occupancy = 0; out_valid = 0; in_ready = 1 in the first cycle after deassert.
  - sbox_in = 0 and out_tag = 0 at reset.
  - Reset mid-stream discards all in-flight beats.
- Illegal NUM_STAGES is rejected at elaboration.

Optional Feature:
- Macro: DES_EXPAND_PARITY_EN.
- Defined:
  - Adds output out_parity [7:0].
  - out_parity[7-g] is the XOR-reduction of sbox_in group g.
  - It is registered in the last stage alongside sbox_in and holds under stall like the data.
  - It resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Expansion wrap, XOR_KEY = 0: R = 32'h0000_0001 -> sbox_in = 48'h8000_0000_0002. R = 32'h8000_0000 -> sbox_in = 48'h4000_0000_0001.
- Standard vector, XOR_KEY = 1, NUM_STAGES = 2: R = 32'hF0AA_F0AA, subkey = 48'h1B02_EFFC_7072 -> E(R) = 48'h7A15_557A_1555 and sbox_in = 48'h6117_BA86_6527, exactly 2 cycles after accept. With the macro defined, out_parity = 8'h04.
- Streaming: 16 back-to-back beats with tags 0..15 and out_ready = 1 -> outputs in order with matching tags, one per cycle, in_ready never low.
- Back-pressure: fill with out_ready = 0 -> occupancy reaches NUM_STAGES, in_ready = 0, and the head output is stable for 10 cycles. Releasing out_ready drains in order; a simultaneous accept and emit keeps occupancy constant.
- Reset mid-stream: assert rst_n = 0 with occupancy = 2 -> out_valid = 0 and occupancy = 0 immediately (async). After release, no stale beats emerge and in_ready = 1.
- Parameter sweep: NUM_STAGES = 1 and 4 with random R/subkey/stall patterns -> scoreboard match against the reference E-table model, with latency equal to NUM_STAGES when unstalled.

Source files
------------

// File: rtl/des_expand_mix_pipe.sv
// des_expand_mix_pipe
// DES E-box expansion of the 32-bit right half to 48 bits, optionally mixed
// with the round subkey, carried through a NUM_STAGES-deep elastic
// valid/ready pipeline together with a sideband tag.
// Optional feature macro: DES_EXPAND_PARITY_EN. When it is defined, the
// out_parity port is present; it carries per-S-box-group parity,
// registered in the last stage.
module des_expand_mix_pipe #(
    parameter int NUM_STAGES = 2,
    parameter int TAG_W      = 4,
    parameter int XOR_KEY    = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       right_half,
    input  logic [47:0]                       subkey,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [47:0]                       sbox_in,
    output logic [TAG_W-1:0]                  out_tag,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
`ifdef DES_EXPAND_PARITY_EN
    ,
    output logic [7:0]                        out_parity
`endif
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 4) begin : g_bad_num_stages
            $error("des_expand_mix_pipe: NUM_STAGES must be in 1..4");
        end
    endgenerate

    logic [47:0]            expanded;
    logic [47:0]            mixed;
    logic [NUM_STAGES-1:0]  vld;
    logic [NUM_STAGES-1:0]  rdy;
    logic [47:0]            data [NUM_STAGES];
    logic [TAG_W-1:0]       tag  [NUM_STAGES];

    // E table: each 6-bit group overlaps its neighbours by one bit and wraps at both ends
    generate
        for (genvar g = 0; g < 8; g++) begin : g_ebox
            assign expanded[47-6*g -: 6] = {right_half[(32-4*g) % 32],
                                            right_half[31-4*g -: 4],
                                            right_half[(59-4*g) % 32]};
        end
    endgenerate

    assign mixed = (XOR_KEY != 0) ? (expanded ^ subkey) : expanded;

    // A stage is ready when any stage from it to the output is empty or the sink accepts,
    // so bubbles anywhere downstream collapse in the same cycle
    always_comb begin
        rdy = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            rdy[k] = out_ready;
            for (int unsigned j = 0; j < NUM_STAGES; j++) begin
                if (j >= k && !vld[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    // Stage registers: valid follows upstream when ready; data and tag load only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                data[k] <= '0;
                tag[k]  <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= mixed;
                    tag[0]  <= in_tag;
                end
            end
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        data[k] <= data[k-1];
                        tag[k]  <= tag[k-1];
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the stage valid bits
    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            occupancy = occupancy + OCC_W'(vld[k]);
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[NUM_STAGES-1];
    assign sbox_in   = data[NUM_STAGES-1];
    assign out_tag   = tag[NUM_STAGES-1];

`ifdef DES_EXPAND_PARITY_EN
    logic [47:0] last_in;
    logic        last_take;
    logic [7:0]  last_par;

    generate
        if (NUM_STAGES == 1) begin : g_last_from_input
            assign last_in   = mixed;
            assign last_take = in_valid && rdy[0];
        end else begin : g_last_from_stage
            assign last_in   = data[NUM_STAGES-2];
            assign last_take = vld[NUM_STAGES-2] && rdy[NUM_STAGES-1];
        end
        for (genvar g = 0; g < 8; g++) begin : g_par
            assign last_par[7-g] = ^last_in[47-6*g -: 6];
        end
    endgenerate

    // Parity is computed from the beat entering the last stage so it travels with sbox_in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= '0;
        end else if (last_take) begin
            out_parity <= last_par;
        end
    end
`endif

endmodule

// File: tb/tb_des_expand_mix_pipe.sv
// tb_des_expand_mix_pipe
// Four configurations share one stimulus stream: (stages=2, xor), (stages=2, no xor),
// (stages=1, xor), (stages=4, xor). Each has a queue-based reference model that
// tracks every beat's position in the pipe. Directed checks cover the known
// vectors, back-pressure and reset. Optional feature macro: DES_EXPAND_PARITY_EN.
module tb_des_expand_mix_pipe;

    localparam int NI = 4;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid;
    logic [31:0]           rh;
    logic [47:0]           sk;
    logic [TW-1:0]         tg;
    logic                  out_rdy;

    logic [NI-1:0]         ir_w;
    logic [NI-1:0]         ov_w;
    logic [NI-1:0][47:0]   sb_w;
    logic [NI-1:0][TW-1:0] ot_w;
    logic [NI-1:0][2:0]    occ_w;
`ifdef DES_EXPAND_PARITY_EN
    logic [NI-1:0][7:0]    par_w;
`endif

    int total = 0;
    int bad = 0;

    // Standard DES E selection table, 1-based DES bit numbers
    int etab [48] = '{32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,
                       8, 9,10,11,12,13,  12,13,14,15,16,17,
                      16,17,18,19,20,21,  20,21,22,23,24,25,
                      24,25,26,27,28,29,  28,29,30,31,32, 1};

    // DES bit n lives at R[32-n]; output bit m lives at sbox_in[48-m]
    function automatic logic [47:0] e_ref(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int m = 1; m <= 48; m++) begin
            e[48-m] = r[32-etab[m-1]];
        end
        return e;
    endfunction

    function automatic logic [7:0] par_ref(input logic [47:0] d);
        logic [7:0] p;
        logic [5:0] grp;
        p = '0;
        for (int g = 0; g < 8; g++) begin
            grp = 6'(d >> (42 - 6*g));
            p[7-g] = ^grp;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar i = 0; i < NI; i++) begin : g_inst
        localparam int N  = (i == 2) ? 1 : ((i == 3) ? 4 : 2);
        localparam int X  = (i == 1) ? 0 : 1;
        localparam int OW = $clog2(N + 1);

        logic [OW-1:0] occ;

        des_expand_mix_pipe #(
            .NUM_STAGES(N),
            .TAG_W(TW),
            .XOR_KEY(X)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid),
            .in_ready(ir_w[i]),
            .right_half(rh),
            .subkey(sk),
            .in_tag(tg),
            .out_valid(ov_w[i]),
            .out_ready(out_rdy),
            .sbox_in(sb_w[i]),
            .out_tag(ot_w[i]),
            .occupancy(occ)
`ifdef DES_EXPAND_PARITY_EN
            ,
            .out_parity(par_w[i])
`endif
        );

        assign occ_w[i] = 3'(occ);

        // Reference model: one queue entry per beat in flight, with its stage position 1..N
        logic [47:0]   q_d [$];
        logic [TW-1:0] q_t [$];
        int            q_p [$];

        always @(negedge rst_n) begin
            q_d.delete();
            q_t.delete();
            q_p.delete();
        end

        always @(posedge clk) begin
            bit acc;
            if (!rst_n) begin
                q_d.delete();
                q_t.delete();
                q_p.delete();
            end else begin
                acc = in_valid && ((q_d.size() < N) || out_rdy);
                if (q_p.size() > 0 && q_p[0] == N && out_rdy) begin
                    void'(q_d.pop_front());
                    void'(q_t.pop_front());
                    void'(q_p.pop_front());
                end
                for (int k = 0; k < q_p.size(); k++) begin
                    if (q_p[k] < N && (k == 0 || q_p[k-1] > q_p[k] + 1)) begin
                        q_p[k] = q_p[k] + 1;
                    end
                end
                if (acc) begin
                    q_d.push_back((X != 0) ? (e_ref(rh) ^ sk) : e_ref(rh));
                    q_t.push_back(tg);
                    q_p.push_back(1);
                end
            end
        end

        always @(negedge clk) begin
            bit ev;
            ev = (q_p.size() > 0) && (q_p[0] == N);
            check($sformatf("occ[%0d]", i), 64'(occ), 64'(q_d.size()));
            check($sformatf("in_ready[%0d]", i), 64'(ir_w[i]), 64'((q_d.size() < N) || out_rdy));
            check($sformatf("out_valid[%0d]", i), 64'(ov_w[i]), 64'(ev));
            if (ev) begin
                check($sformatf("sbox_in[%0d]", i), 64'(sb_w[i]), 64'(q_d[0]));
                check($sformatf("out_tag[%0d]", i), 64'(ot_w[i]), 64'(q_t[0]));
`ifdef DES_EXPAND_PARITY_EN
                check($sformatf("parity[%0d]", i), 64'(par_w[i]), 64'(par_ref(q_d[0])));
`endif
            end
        end
    end

    logic [47:0]   head;
    logic [TW-1:0] head_tag;

    initial begin
        in_valid = 1'b0;
        rh       = '0;
        sk       = '0;
        tg       = '0;
        out_rdy  = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        for (int i = 0; i < NI; i++) begin
            check("rst_sbox", 64'(sb_w[i]), 64'h0);
            check("rst_tag", 64'(ot_w[i]), 64'h0);
            check("rst_valid", 64'(ov_w[i]), 64'h0);
            check("rst_ready", 64'(ir_w[i]), 64'h1);
`ifdef DES_EXPAND_PARITY_EN
            check("rst_parity", 64'(par_w[i]), 64'h0);
`endif
        end

        // expansion wrap-around, no key mixing (instance 1)
        rh = 32'h0000_0001; sk = 48'({$urandom(), $urandom()}); tg = 4'd1; in_valid = 1'b1;
        step();
        rh = 32'h8000_0000; sk = 48'({$urandom(), $urandom()}); tg = 4'd2;
        step();
        in_valid = 1'b0;
        check("wrap_lo_valid", 64'(ov_w[1]), 64'h1);
        check("wrap_lo", 64'(sb_w[1]), 64'h8000_0000_0002);
        step();
        check("wrap_hi", 64'(sb_w[1]), 64'h4000_0000_0001);
        check("wrap_hi_tag", 64'(ot_w[1]), 64'h2);
        repeat (5) step();

        // standard vector, two-stage latency
        rh = 32'hF0AA_F0AA; sk = 48'h1B02_EFFC_7072; tg = 4'h9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("std_early", 64'(ov_w[0]), 64'h0);
        step();
        check("std_valid", 64'(ov_w[0]), 64'h1);
        check("std_sbox", 64'(sb_w[0]), 64'h6117_BA86_6527);
        check("std_tag", 64'(ot_w[0]), 64'h9);
        check("std_ebox", 64'(sb_w[1]), 64'h7A15_557A_1555);
`ifdef DES_EXPAND_PARITY_EN
        check("std_parity", 64'(par_w[0]), 64'h04);
`endif
        repeat (5) step();

        // streaming, 16 back-to-back beats
        out_rdy = 1'b1;
        for (int t = 0; t < 16; t++) begin
            rh = $urandom(); sk = 48'({$urandom(), $urandom()}); tg = 4'(t); in_valid = 1'b1;
            check("stream_ready", 64'(ir_w[0]), 64'h1);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();

        // back-pressure: fill, hold, then drain with simultaneous accept/emit
        out_rdy = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            rh = $urandom(); sk = 48'({$urandom(), $urandom()}); tg = 4'($urandom());
            step();
        end
        check("bp_occ_full", 64'(occ_w[0]), 64'h2);
        check("bp_in_ready", 64'(ir_w[0]), 64'h0);
        check("bp_valid", 64'(ov_w[0]), 64'h1);
        head = sb_w[0];
        head_tag = ot_w[0];
        for (int t = 0; t < 10; t++) begin
            step();
            check("bp_hold_sbox", 64'(sb_w[0]), 64'(head));
            check("bp_hold_tag", 64'(ot_w[0]), 64'(head_tag));
            check("bp_hold_valid", 64'(ov_w[0]), 64'h1);
        end
        out_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check("bp_occ_steady", 64'(occ_w[0]), 64'h2);
            rh = $urandom(); sk = 48'({$urandom(), $urandom()}); tg = 4'($urandom());
        end
        in_valid = 1'b0;
        repeat (6) step();

        // reset mid-stream with two beats in flight
        out_rdy = 1'b0;
        in_valid = 1'b1;
        rh = $urandom(); sk = 48'({$urandom(), $urandom()}); tg = 4'hA;
        step();
        tg = 4'hB;
        step();
        in_valid = 1'b0;
        check("mid_occ", 64'(occ_w[0]), 64'h2);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("mid_rst_valid", 64'(ov_w[i]), 64'h0);
            check("mid_rst_occ", 64'(occ_w[i]), 64'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            check("post_rst_valid", 64'(ov_w[0]), 64'h0);
            check("post_rst_ready", 64'(ir_w[0]), 64'h1);
            step();
        end

        // random traffic and stalls across all configurations
        for (int t = 0; t < 800; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_rdy  = ($urandom_range(0, 3) != 0);
            rh = $urandom(); sk = 48'({$urandom(), $urandom()}); tg = 4'($urandom());
            step();
        end
        in_valid = 1'b0;
        out_rdy = 1'b1;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
